// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request port, big-endian byte array behind a
// programmable wait latency, one-cycle response strobe with alignment error flag.
module data_mem_responder #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_se,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ready_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              se_q;
    logic [31:0]       wdata_q;

    logic [7:0]        mem [2**ADDR_W];

    logic              accept;
    logic              req_err;
    logic              commit;
    logic              err_entry;

    logic              c_rw;
    logic [ADDR_W-1:0] c_addr;
    logic [1:0]        c_size;
    logic              c_se;
    logic [31:0]       c_wdata;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [7:0]        b0, b1, b2, b3;
    logic [31:0]       load_data;

    assign accept  = req_valid & ready_q;
    assign req_err = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));

    // With LAT=0 the access commits on the accept edge, before the capture registers load.
    always_comb begin
        if (state_q == StIdle) begin
            c_rw    = req_rw;
            c_addr  = req_addr;
            c_size  = req_size;
            c_se    = req_se;
            c_wdata = req_wdata;
        end else begin
            c_rw    = rw_q;
            c_addr  = addr_q;
            c_size  = size_q;
            c_se    = se_q;
            c_wdata = wdata_q;
        end
    end

    assign a0 = c_addr;
    assign a1 = c_addr + ADDR_W'(1);
    assign a2 = c_addr + ADDR_W'(2);
    assign a3 = c_addr + ADDR_W'(3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    always_comb begin
        case (c_size)
            2'b00:   load_data = {{24{c_se & b0[7]}}, b0};
            2'b01:   load_data = {{16{c_se & b0[7]}}, b0, b1};
            default: load_data = {b0, b1, b2, b3};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;
        err_entry = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_err) begin
                        state_d   = StResp;
                        err_entry = 1'b1;
                    end else if (LAT == 0) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(LAT - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StResp;
                    commit  = 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            ready_q     <= 1'b1;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            size_q      <= 2'b00;
            se_q        <= 1'b0;
            wdata_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == StIdle);
            if (accept) begin
                rw_q    <= req_rw;
                addr_q  <= req_addr;
                size_q  <= req_size;
                se_q    <= req_se;
                wdata_q <= req_wdata;
            end
            if (err_entry) begin
                rsp_rdata_q <= 32'd0;
                rsp_err_q   <= 1'b1;
            end else if (commit) begin
                rsp_rdata_q <= c_rw ? 32'd0 : load_data;
                rsp_err_q   <= 1'b0;
            end
        end
    end

    // Array has no reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && c_rw) begin
            case (c_size)
                2'b00: mem[a0] <= c_wdata[7:0];
                2'b01: begin
                    mem[a0] <= c_wdata[15:8];
                    mem[a1] <= c_wdata[7:0];
                end
                2'b10: begin
                    mem[a0] <= c_wdata[31:24];
                    mem[a1] <= c_wdata[23:16];
                    mem[a2] <= c_wdata[15:8];
                    mem[a3] <= c_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LAT=2, 4, 0), vector table plus
// hand-written reset-abort and back-to-back sequences, checked through a scoreboard queue.
module tb_data_mem_responder;

    typedef struct {
        logic        rw;
        logic [8:0]  addr;
        logic [1:0]  size;
        logic        se;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        rv    [3];
    logic        rdy   [3];
    logic        rw    [3];
    logic [8:0]  addr  [3];
    logic [1:0]  size  [3];
    logic        se    [3];
    logic [31:0] wd    [3];
    logic        vld   [3];
    logic [31:0] rdata [3];
    logic        err   [3];

    int lat_of [3] = '{2, 4, 0};
    int n_cmp  = 0;
    int n_fail = 0;
    exp_t sb[$];
    vec_t vecs[18];

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(9), .LAT(2)) u_dut0 (
        .clk(clk), .reset(rst_n[0]), .req_valid(rv[0]), .req_ready(rdy[0]), .req_rw(rw[0]),
        .req_addr(addr[0]), .req_size(size[0]), .req_se(se[0]), .req_wdata(wd[0]),
        .rsp_valid(vld[0]), .rsp_rdata(rdata[0]), .rsp_err(err[0])
    );
    data_mem_responder #(.ADDR_W(9), .LAT(4)) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .req_valid(rv[1]), .req_ready(rdy[1]), .req_rw(rw[1]),
        .req_addr(addr[1]), .req_size(size[1]), .req_se(se[1]), .req_wdata(wd[1]),
        .rsp_valid(vld[1]), .rsp_rdata(rdata[1]), .rsp_err(err[1])
    );
    data_mem_responder #(.ADDR_W(9), .LAT(0)) u_dut2 (
        .clk(clk), .reset(rst_n[2]), .req_valid(rv[2]), .req_ready(rdy[2]), .req_rw(rw[2]),
        .req_addr(addr[2]), .req_size(size[2]), .req_se(se[2]), .req_wdata(wd[2]),
        .rsp_valid(vld[2]), .rsp_rdata(rdata[2]), .rsp_err(err[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int i, input logic r, input logic [8:0] a, input logic [1:0] s,
                         input logic e, input logic [31:0] w);
        rw[i]   = r;
        addr[i] = a;
        size[i] = s;
        se[i]   = e;
        wd[i]   = w;
    endtask

    // Called at a negedge; returns at the negedge after the response cycle.
    task automatic do_req(input int i, input string name, input vec_t v);
        exp_t ex;
        exp_t got;
        int   k;
        int   busy_rdy;
        bit   done;
        ex.rdata = v.exp_rdata;
        ex.err   = v.exp_err;
        ex.lat   = v.exp_err ? 1 : lat_of[i] + 1;
        sb.push_back(ex);
        drive(i, v.rw, v.addr, v.size, v.se, v.wdata);
        rv[i] = 1'b1;
        done  = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            if (rdy[i]) done = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        rv[i] = 1'b0;
        if (!done) begin
            check({name, " accept timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
            return;
        end
        k        = 1;
        busy_rdy = 0;
        done     = 1'b0;
        while (!done && k < 40) begin
            if (rdy[i]) busy_rdy++;
            if (vld[i]) done = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        got = sb.pop_front();
        if (!done) begin
            check({name, " response timeout"}, 32'd0, 32'd1);
            return;
        end
        check({name, " rdata"}, rdata[i], got.rdata);
        check({name, " err"}, 32'(err[i]), 32'(got.err));
        check({name, " latency"}, 32'(k), 32'(got.lat));
        check({name, " ready low while busy"}, 32'(busy_rdy), 32'd0);
        @(negedge clk);
        check({name, " single-cycle valid"}, 32'(vld[i]), 32'd0);
        check({name, " ready after resp"}, 32'(rdy[i]), 32'd1);
    endtask

    initial begin
        vec_t v;
        int   hits;
        int   nacc;
        int   overlap;
        int   acc_c [2];
        bit   pend;

        vecs[0]  = '{1'b1, 9'h010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 9'h010, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 9'h010, 2'b00, 1'b0, 32'h0,        32'h000000DE, 1'b0};
        vecs[3]  = '{1'b0, 9'h011, 2'b00, 1'b1, 32'h0,        32'hFFFFFFAD, 1'b0};
        vecs[4]  = '{1'b0, 9'h012, 2'b01, 1'b1, 32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[5]  = '{1'b0, 9'h012, 2'b01, 1'b0, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[6]  = '{1'b0, 9'h010, 2'b10, 1'b1, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b1, 9'h013, 2'b00, 1'b0, 32'h00000055, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b1, 9'h010, 2'b01, 1'b0, 32'h00001234, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b0, 9'h010, 2'b10, 1'b0, 32'h0,        32'h1234BE55, 1'b0};
        vecs[10] = '{1'b0, 9'h012, 2'b10, 1'b0, 32'h0,        32'h00000000, 1'b1};
        vecs[11] = '{1'b1, 9'h011, 2'b01, 1'b0, 32'h0000FFFF, 32'h00000000, 1'b1};
        vecs[12] = '{1'b0, 9'h010, 2'b10, 1'b0, 32'h0,        32'h1234BE55, 1'b0};
        vecs[13] = '{1'b0, 9'h010, 2'b11, 1'b0, 32'h0,        32'h00000000, 1'b1};
        vecs[14] = '{1'b0, 9'h013, 2'b00, 1'b1, 32'h0,        32'h00000055, 1'b0};
        vecs[15] = '{1'b0, 9'h010, 2'b01, 1'b1, 32'h0,        32'h00001234, 1'b0};
        vecs[16] = '{1'b1, 9'h1FC, 2'b10, 1'b0, 32'hA1B2C3D4, 32'h00000000, 1'b0};
        vecs[17] = '{1'b0, 9'h1FF, 2'b00, 1'b0, 32'h0,        32'h000000D4, 1'b0};

        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            rv[i]    = 1'b0;
            drive(i, 1'b0, 9'h0, 2'b00, 1'b0, 32'h0);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset%0d ready", i), 32'(rdy[i]), 32'd1);
            check($sformatf("reset%0d valid", i), 32'(vld[i]), 32'd0);
            check($sformatf("reset%0d rdata", i), rdata[i], 32'd0);
            check($sformatf("reset%0d err", i), 32'(err[i]), 32'd0);
        end
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (vld[i]) hits++;
        end
        check("idle no response", 32'(hits), 32'd0);

        for (int k = 0; k < 18; k++) do_req(0, $sformatf("vec%0d", k), vecs[k]);

        // Reset aborting a LAT=4 store in WAIT.
        v = '{1'b1, 9'h020, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0};
        do_req(1, "pre-store", v);
        drive(1, 1'b1, 9'h020, 2'b10, 1'b0, 32'hCAFEF00D);
        rv[1] = 1'b1;
        check("abort store ready", 32'(rdy[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rv[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n[1] = 1'b0;
        hits = 0;
        @(negedge clk);
        if (vld[1]) hits++;
        rst_n[1] = 1'b1;
        #1;
        check("abort ready after release", 32'(rdy[1]), 32'd1);
        repeat (8) begin
            @(negedge clk);
            if (vld[1]) hits++;
        end
        check("abort no response", 32'(hits), 32'd0);
        v = '{1'b0, 9'h020, 2'b10, 1'b0, 32'h0, 32'h11223344, 1'b0};
        do_req(1, "after abort", v);

        // LAT=0 back-to-back loads with req_valid held high.
        v = '{1'b1, 9'h040, 2'b10, 1'b0, 32'h0BADCAFE, 32'h0, 1'b0};
        do_req(2, "b2b store", v);
        sb.push_back('{32'h0BADCAFE, 1'b0, 1});
        sb.push_back('{32'h0000CAFE, 1'b0, 1});
        drive(2, 1'b0, 9'h040, 2'b10, 1'b0, 32'h0);
        rv[2]   = 1'b1;
        nacc    = 0;
        overlap = 0;
        acc_c   = '{0, 0};
        for (int c = 0; c < 12; c++) begin
            if (vld[2] && rdy[2]) overlap++;
            if (vld[2]) begin
                exp_t ex;
                if (sb.size() == 0) check("b2b extra response", 32'd1, 32'd0);
                else begin
                    ex = sb.pop_front();
                    check($sformatf("b2b rdata c%0d", c), rdata[2], ex.rdata);
                    check($sformatf("b2b err c%0d", c), 32'(err[2]), 32'(ex.err));
                    check($sformatf("b2b latency c%0d", c), 32'(c - acc_c[nacc > 0 ? nacc - 1 : 0]),
                          32'(ex.lat));
                end
            end
            pend = rv[2] && rdy[2];
            if (pend && nacc < 2) acc_c[nacc] = c;
            @(posedge clk);
            @(negedge clk);
            if (pend) begin
                nacc++;
                if (nacc == 1) drive(2, 1'b0, 9'h042, 2'b01, 1'b0, 32'h0);
                else rv[2] = 1'b0;
            end
        end
        check("b2b accepts", 32'(nacc), 32'd2);
        check("b2b spacing", 32'(acc_c[1] - acc_c[0]), 32'd2);
        check("b2b ready/valid overlap", 32'(overlap), 32'd0);
        check("b2b scoreboard drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
